ddr_port_arbiter: RTL and testbench

//  Shares the single DDR2 controller user port (MIG-style app_* interface) between two CPU masters:

---
 rtl/ddr_arb_pkg.sv | 15 +
 rtl/ddr_arb_grant.sv | 46 ++++
 rtl/ddr_port_arbiter.sv | 118 +++++++++++
 tb/tb_ddr_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-port DDR2 user-port arbiter.
package ddr_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    CMD   = 2'd2,
    RWAIT = 2'd3
  } state_t;

  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WR = 3'b000;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
endpackage

// File: rtl/ddr_arb_grant.sv
// Two-way grant: round-robin when DDR_ARB_RR_EN is defined, otherwise fixed
// priority with the data port (p1) winning over fetch (p0).
module ddr_arb_grant
  import ddr_arb_pkg::*;
(
`ifdef DDR_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

`ifdef DDR_ARB_RR_EN
  logic last;  // port granted most recently

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= PORT_FETCH;
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        gnt1 = (last == PORT_FETCH);
        gnt0 = (last == PORT_DATA);
      end else begin
        gnt0 = valid0;
        gnt1 = valid1;
      end
    end
  end
`else
  assign gnt1 = en & valid1;
  assign gnt0 = en & valid0 & ~valid1;
`endif

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one MIG-style app_* port between fetch (p0, read-only) and data (p1)
// masters, one line transaction at a time. Arbitration mode: DDR_ARB_RR_EN.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic [ADDR_W-1:0]   p0_addr,
  output logic                p0_resp_valid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic                p1_we,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wmask,
  output logic                p1_resp_valid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  owner_q;
  logic                  grant_en, gnt0, gnt1, granted, rd_done, wr_done;

  // Grants wait out the response-pulse cycle so a new transaction starts
  // the cycle after resp_valid; reset gating keeps req_ready low in reset.
  assign grant_en = (state_q == IDLE) && calib_done && !reset &&
                    !p0_resp_valid && !p1_resp_valid;

  ddr_arb_grant u_grant (
`ifdef DDR_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .en     (grant_en),
    .valid0 (p0_req_valid),
    .valid1 (p1_req_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign granted = gnt0 | gnt1;
  assign rd_done = (state_q == RWAIT) && app_rd_data_valid;
  assign wr_done = (state_q == CMD) && app_rdy && we_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (granted) state_d = (gnt1 && p1_we) ? WDATA : CMD;
      WDATA:   if (app_wdf_rdy) state_d = CMD;
      CMD:     if (app_rdy) state_d = we_q ? IDLE : RWAIT;
      RWAIT:   if (app_rd_data_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      owner_q       <= PORT_FETCH;
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
    end else begin
      state_q       <= state_d;
      p0_resp_valid <= rd_done && (owner_q == PORT_FETCH);
      p1_resp_valid <= (rd_done && (owner_q == PORT_DATA)) || wr_done;
      if (granted) begin
        addr_q  <= gnt1 ? p1_addr : p0_addr;
        we_q    <= gnt1 & p1_we;
        wdata_q <= gnt1 ? p1_wdata : '0;
        wmask_q <= gnt1 ? p1_wmask : '0;
        owner_q <= gnt1 ? PORT_DATA : PORT_FETCH;
      end
      if (rd_done) begin
        if (owner_q == PORT_FETCH) p0_rdata <= app_rd_data;
        else                       p1_rdata <= app_rd_data;
      end
    end
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign app_en       = (state_q == CMD);
  assign app_cmd      = (state_q == CMD && !we_q) ? CMD_RD : CMD_WR;
  assign app_addr     = addr_q;
  assign app_wdf_wren = (state_q == WDATA);
  assign app_wdf_end  = (state_q == WDATA);
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = wmask_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter (either arbitration mode).
module tb_ddr_port_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         calib_done;
  logic         p0_req_valid, p0_req_ready, p0_resp_valid;
  logic [26:0]  p0_addr;
  logic [127:0] p0_rdata;
  logic         p1_req_valid, p1_req_ready, p1_we, p1_resp_valid;
  logic [26:0]  p1_addr;
  logic [127:0] p1_wdata, p1_rdata;
  logic [15:0]  p1_wmask;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.ADDR_W(27), .DATA_W(128)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
    .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
    .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] DEAD = {4{32'hDEADBEEF}};
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] C3   = {8{16'hC3C3}};

  logic [7:0] exp_gnt;
  int unsigned left0, left1;
  logic        g1;

  initial begin
    reset = 1'b1; calib_done = 1'b1;
    p0_req_valid = 1'b0; p0_addr = '0;
    p1_req_valid = 1'b0; p1_addr = '0; p1_we = 1'b0; p1_wdata = '0; p1_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    tick; tick;
    chk("rst_app_en", 128'(app_en), 128'h0);
    chk("rst_app_cmd", 128'(app_cmd), 128'h0);
    chk("rst_app_addr", 128'(app_addr), 128'h0);
    chk("rst_wren", 128'(app_wdf_wren), 128'h0);
    chk("rst_p0_rdata", p0_rdata, 128'h0);
    reset = 1'b0;

    // Test 1: p0 read 0x100, data arrives 10 cycles after the command
    tick;
    p0_req_valid = 1'b1; p0_addr = 27'h100; #1;
    chk("t1_p0_ready", 128'(p0_req_ready), 128'h1);
    chk("t1_p1_ready", 128'(p1_req_ready), 128'h0);
    tick; p0_req_valid = 1'b0;
    chk("t1_app_en", 128'(app_en), 128'h1);
    chk("t1_app_addr", 128'(app_addr), 128'h100);
    chk("t1_app_cmd", 128'(app_cmd), 128'h1);
    tick;
    chk("t1_app_en_off", 128'(app_en), 128'h0);
    for (int i = 0; i < 9; i++) begin
      chk("t1_no_resp", 128'(p0_resp_valid), 128'h0);
      tick;
    end
    app_rd_data = DEAD; app_rd_data_valid = 1'b1;
    tick; app_rd_data_valid = 1'b0; app_rd_data = '0;
    chk("t1_p0_resp", 128'(p0_resp_valid), 128'h1);
    chk("t1_p0_rdata", p0_rdata, DEAD);
    chk("t1_p1_silent", 128'(p1_resp_valid), 128'h0);
    tick;
    chk("t1_p0_resp_pulse", 128'(p0_resp_valid), 128'h0);
    chk("t1_p0_rdata_hold", p0_rdata, DEAD);

    // Test 2: p1 write 0x200, wdf_rdy low for 3 cycles
    p1_req_valid = 1'b1; p1_addr = 27'h200; p1_we = 1'b1; p1_wdata = A5; p1_wmask = 16'h0000; #1;
    chk("t2_p1_ready", 128'(p1_req_ready), 128'h1);
    tick; p1_req_valid = 1'b0; p1_we = 1'b0; p1_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) app_wdf_rdy = 1'b1;
      #1;
      chk("t2_wren", 128'(app_wdf_wren), 128'h1);
      chk("t2_wend", 128'(app_wdf_end), 128'h1);
      chk("t2_wdata", app_wdf_data, A5);
      chk("t2_wmask", 128'(app_wdf_mask), 128'h0);
      chk("t2_no_en", 128'(app_en), 128'h0);
      tick;
    end
    app_wdf_rdy = 1'b0;
    chk("t2_wren_off", 128'(app_wdf_wren), 128'h0);
    chk("t2_app_en", 128'(app_en), 128'h1);
    chk("t2_app_cmd", 128'(app_cmd), 128'h0);
    chk("t2_app_addr", 128'(app_addr), 128'h200);
    tick;
    chk("t2_p1_ack", 128'(p1_resp_valid), 128'h1);
    chk("t2_p0_silent", 128'(p0_resp_valid), 128'h0);
    chk("t2_en_off", 128'(app_en), 128'h0);
    tick;
    chk("t2_ack_pulse", 128'(p1_resp_valid), 128'h0);

    // Test 6: p1 read 0x3AB with app_rdy low 5 cycles in CMD
    app_rdy = 1'b0;
    p1_req_valid = 1'b1; p1_addr = 27'h3AB; p1_we = 1'b0; #1;
    chk("t6_p1_ready", 128'(p1_req_ready), 128'h1);
    tick; p1_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) app_rdy = 1'b1;
      #1;
      chk("t6_app_en", 128'(app_en), 128'h1);
      chk("t6_app_addr", 128'(app_addr), 128'h3AB);
      chk("t6_app_cmd", 128'(app_cmd), 128'h1);
      tick;
    end
    chk("t6_single_accept", 128'(app_en), 128'h0);
    app_rd_data = C3; app_rd_data_valid = 1'b1;
    tick; app_rd_data_valid = 1'b0;
    chk("t6_p1_resp", 128'(p1_resp_valid), 128'h1);
    chk("t6_p1_rdata", p1_rdata, C3);
    chk("t6_p0_rdata_hold", p0_rdata, DEAD);
    tick;

    // Test 5: reset while waiting for read data
    p0_req_valid = 1'b1; p0_addr = 27'h040; #1;
    chk("t5_p0_ready", 128'(p0_req_ready), 128'h1);
    tick; p0_req_valid = 1'b0;
    tick;
    chk("t5_in_rwait", 128'(app_en), 128'h0);
    reset = 1'b1; #1;
    chk("t5_rst_en", 128'(app_en), 128'h0);
    chk("t5_rst_addr", 128'(app_addr), 128'h0);
    chk("t5_rst_p0_rdata", p0_rdata, 128'h0);
    chk("t5_rst_p1_rdata", p1_rdata, 128'h0);
    chk("t5_rst_resp", 128'({p0_resp_valid, p1_resp_valid}), 128'h0);
    tick; tick;
    reset = 1'b0;
    tick;
    app_rd_data = DEAD; app_rd_data_valid = 1'b1;
    tick; app_rd_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_resp", 128'({p0_resp_valid, p1_resp_valid, app_en}), 128'h0);
      chk("t5_p0_rdata_clear", p0_rdata, 128'h0);
      tick;
    end

    // Test 4: both valid with calibration incomplete
    calib_done = 1'b0; app_rdy = 1'b1;
    p0_req_valid = 1'b1; p0_addr = 27'h0AA;
    p1_req_valid = 1'b1; p1_addr = 27'h0BB; p1_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_no_ready", 128'({p0_req_ready, p1_req_ready}), 128'h0);
      chk("t4_no_en", 128'(app_en), 128'h0);
      tick;
    end

    // Test 3: four back-to-back reads per port, grant order by mode
`ifdef DDR_ARB_RR_EN
    exp_gnt = 8'b01010101;
`else
    exp_gnt = 8'b00001111;
`endif
    left0 = 4; left1 = 4;
    calib_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      p0_req_valid = (left0 != 0);
      p1_req_valid = (left1 != 0);
      #1;
      g1 = exp_gnt[k];
      chk("t3_p1_ready", 128'(p1_req_ready), 128'(g1));
      chk("t3_p0_ready", 128'(p0_req_ready), 128'(!g1));
      if (g1) left1--; else left0--;
      tick;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      chk("t3_app_en", 128'(app_en), 128'h1);
      chk("t3_app_addr", 128'(app_addr), g1 ? 128'h0BB : 128'h0AA);
      tick;
      app_rd_data = 128'(k + 1); app_rd_data_valid = 1'b1;
      tick; app_rd_data_valid = 1'b0;
      chk("t3_resp", 128'({p1_resp_valid, p0_resp_valid}), g1 ? 128'h2 : 128'h1);
      chk("t3_rdata", g1 ? p1_rdata : p0_rdata, 128'(k + 1));
      tick;
    end
    #1;
    chk("t3_drained", 128'({p0_req_ready, p1_req_ready, app_en}), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
